inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Instruction-memory responder for the `openmips` core's fetch port: it returns the instruction word for each fetch address and chip-enable the core presents. It also owns program loading. A byte-serial loader port fills the memory, and the block holds the core in reset until loading completes. It sits beside `openmips` at the SoC top, driving the core's `rom_data_i` and its `rst`.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: log2 of memory depth in 32-bit words (default 1024 words).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rom_ce_i` input 1: fetch chip-enable from core.
- `rom_addr_i` input 32: fetch byte address from core; word index = `rom_addr_i[ADDR_WIDTH+1:2]`.
- `rom_data_o` output 32: instruction word to core.
- `load_valid_i` input 1: loader byte valid.
- `load_byte_i` input 8: loader byte.
- `load_last_i` input 1: marks final byte of the image; qualified by `load_valid_i`.
- `load_ready_o` output 1: block accepts a byte this cycle.
- `reload_i` input 1: single-cycle request to re-enter loading.
- `cpu_rst_o` output 1: reset to core, active-high.
- `words_loaded_o` output ADDR_WIDTH+1: count of words written in the current load.
- `full_o` output 1: load ended because memory capacity was reached.

## Operation
- States: LOAD, RUN.
- A byte is accepted when `load_valid_i & load_ready_o`.
- Reset (`rst`=1) sets:
  - state=LOAD, byte_cnt=0, word_ptr=0, assembly register=0;
  - `cpu_rst_o`=1, `load_ready_o`=1, `words_loaded_o`=0, `full_o`=0.
- Memory array is not reset; contents persist across `rst` and reload.
- LOAD:
  - Each accepted byte shifts into a big-endian assembly register. The first byte of a word becomes bits 31:24; the fourth becomes bits 7:0.
  - On the 4th byte (byte_cnt=3), write `{asm[23:0], load_byte_i}` to mem[word_ptr]. Then word_ptr+1, byte_cnt=0, `words_loaded_o`+1.
  - On an accepted byte with `load_last_i`=1 and byte_cnt<3, zero-pad the remaining low bytes and write the word at the same edge.
  - An accepted byte with `load_last_i`=1 always transitions to RUN.
  - A write into word DEPTH-1 without `load_last_i` transitions to RUN and sets `full_o`=1.
- RUN:
  - `load_ready_o`=0 and `cpu_rst_o`=0.
  - `load_valid_i` is ignored; no bytes are accepted.
  - `reload_i`=1 returns to LOAD with byte_cnt=0, word_ptr=0, `words_loaded_o`=0, `full_o`=0, and `cpu_rst_o`=1.
  - `reload_i` in LOAD is ignored.
- Read path (combinational):
  - `rom_data_o` = mem[word index] when state=RUN and `rom_ce_i`=1.
  - Otherwise `rom_data_o`=32'h0.
  - Addresses beyond depth alias by truncation.
  - `rom_addr_i[1:0]` is ignored.
- Simultaneous events:
  - `rst` overrides `reload_i` and any byte acceptance.
  - `reload_i` in RUN takes effect at the same edge as any stray `load_valid_i`; that byte is not accepted.

## Timing
- Byte accepted at edge N: write to memory at edge N. The word is readable from cycle N+1 once in RUN.
- Final byte at edge N: state=RUN, `load_ready_o`=0 and `cpu_rst_o`=0 from cycle N+1. The core's first fetch (pc=0) sees the loaded word in that same cycle.
- `reload_i` sampled at edge N: `cpu_rst_o`=1 and `load_ready_o`=1 from cycle N+1.
- Read latency is zero cycles (combinational), matching the core's registered-PC fetch with if_id capture.
- `rst` mid-load: next cycle is LOAD with counters cleared. Partially written words remain in memory.
- Throughput: one byte per cycle; `load_ready_o` has no bubbles while in LOAD.

## Test plan
- Reset, then stream 8 bytes 34,01,11,00,34,02,00,20 (hex), last on the 8th:
  - mem[0]=34011100, mem[1]=34020020, `words_loaded_o`=2.
  - `cpu_rst_o` falls the cycle after the 8th byte.
  - With `rom_ce_i`=1 and addr 0x4, `rom_data_o`=34020020.
- Stream 6 bytes AA,BB,CC,DD,11,22 with last on the 6th:
  - mem[1]=11220000, `words_loaded_o`=2, `full_o`=0.
- With ADDR_WIDTH=2, stream 20 bytes with no last:
  - RUN entered after the 16th byte, `full_o`=1, `load_ready_o`=0.
  - Bytes 17-20 are not accepted; mem unchanged by them.
- In RUN, `rom_ce_i`=0 gives `rom_data_o`=0. Addr 0x1003 with ADDR_WIDTH=10 reads mem[0].
- In RUN, pulse `reload_i`:
  - `cpu_rst_o`=1 next cycle, `words_loaded_o`=0, old mem[1] still readable after a 1-word reload ends.
  - `reload_i` and `rst` together end in LOAD with counters cleared.
- Assert `rst` after 2 bytes of a word, then load 4 bytes 01,02,03,04 last:
  - mem[0]=01020304; no leftover bytes from before the reset are included.

Source files
------------

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the openmips fetch port, filled by a byte-serial loader.
// Holds the core in reset while an image is being loaded.
module inst_rom_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_byte_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    input  logic                  reload_i,
    output logic                  cpu_rst_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o,
    output logic                  full_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state, state_nxt;
    logic [1:0]            byte_cnt, byte_cnt_nxt;
    logic [ADDR_WIDTH-1:0] word_ptr, word_ptr_nxt;
    logic [23:0]           asm_q, asm_nxt;
    logic [ADDR_WIDTH:0]   words_nxt;
    logic                  full_nxt;
    logic                  wr_en;
    logic [31:0]           wr_data;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  unused_addr;

    logic [31:0] mem [DEPTH];

    // Next-state: byte assembly, word write strobes and LOAD/RUN transitions
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        word_ptr_nxt = word_ptr;
        asm_nxt      = asm_q;
        words_nxt    = words_loaded_o;
        full_nxt     = full_o;
        wr_en        = 1'b0;
        wr_data      = 32'h0;
        case (state)
            ST_LOAD: begin
                if (load_valid_i) begin
                    asm_nxt      = {asm_q[15:0], load_byte_i};
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0:    wr_data = {load_byte_i, 24'h0};
                        2'd1:    wr_data = {asm_q[7:0], load_byte_i, 16'h0};
                        2'd2:    wr_data = {asm_q[15:0], load_byte_i, 8'h0};
                        default: wr_data = {asm_q[23:0], load_byte_i};
                    endcase
                    if ((byte_cnt == 2'd3) || load_last_i) begin
                        wr_en        = 1'b1;
                        word_ptr_nxt = word_ptr + ADDR_WIDTH'(1);
                        byte_cnt_nxt = 2'd0;
                        asm_nxt      = 24'h0;
                        words_nxt    = words_loaded_o + (ADDR_WIDTH+1)'(1);
                        if (load_last_i) begin
                            state_nxt = ST_RUN;
                        end else if (&word_ptr) begin
                            state_nxt = ST_RUN;
                            full_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // Stray loader bytes are dropped; reload wins at the same edge
                if (reload_i) begin
                    state_nxt    = ST_LOAD;
                    byte_cnt_nxt = 2'd0;
                    word_ptr_nxt = '0;
                    asm_nxt      = 24'h0;
                    words_nxt    = '0;
                    full_nxt     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_LOAD;
            byte_cnt       <= 2'd0;
            word_ptr       <= '0;
            asm_q          <= 24'h0;
            words_loaded_o <= '0;
            full_o         <= 1'b0;
            load_ready_o   <= 1'b1;
            cpu_rst_o      <= 1'b1;
        end else begin
            state          <= state_nxt;
            byte_cnt       <= byte_cnt_nxt;
            word_ptr       <= word_ptr_nxt;
            asm_q          <= asm_nxt;
            words_loaded_o <= words_nxt;
            full_o         <= full_nxt;
            load_ready_o   <= (state_nxt == ST_LOAD);
            cpu_rst_o      <= (state_nxt == ST_LOAD);
        end
    end

    // Memory is deliberately not reset so images survive rst and reload
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[word_ptr] <= wr_data;
        end
    end

    assign rd_idx      = rom_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};
    assign rom_data_o  = ((state == ST_RUN) && rom_ce_i) ? mem[rd_idx] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: a 1024-word instance and a 4-word instance.
module tb_inst_rom_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // side a: ADDR_WIDTH=10, side b: ADDR_WIDTH=2
    logic        rst_a, ce_a, valid_a, last_a, reload_a, ready_a, crst_a, full_a;
    logic [31:0] addr_a, data_a;
    logic [7:0]  byte_a;
    logic [10:0] words_a;
    logic        rst_b, ce_b, valid_b, last_b, reload_b, ready_b, crst_b, full_b;
    logic [31:0] addr_b, data_b;
    logic [7:0]  byte_b;
    logic [2:0]  words_b;

    inst_rom_loader #(.ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst_a), .rom_ce_i(ce_a), .rom_addr_i(addr_a), .rom_data_o(data_a),
        .load_valid_i(valid_a), .load_byte_i(byte_a), .load_last_i(last_a),
        .load_ready_o(ready_a), .reload_i(reload_a), .cpu_rst_o(crst_a),
        .words_loaded_o(words_a), .full_o(full_a)
    );

    inst_rom_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst_b), .rom_ce_i(ce_b), .rom_addr_i(addr_b), .rom_data_o(data_b),
        .load_valid_i(valid_b), .load_byte_i(byte_b), .load_last_i(last_b),
        .load_ready_o(ready_b), .reload_i(reload_b), .cpu_rst_o(crst_b),
        .words_loaded_o(words_b), .full_o(full_b)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] data;
        bit          crst;
        bit          rdy;
        bit          full;
        int          words;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: pops one expectation per cycle and compares it against the chosen instance
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t        e;
            logic [31:0] gd;
            bit          gc, gr, gf;
            int          gw;
            e = exp_q.pop_front();
            if (e.sel) begin
                gd = data_b; gc = crst_b; gr = ready_b; gf = full_b; gw = int'(words_b);
            end else begin
                gd = data_a; gc = crst_a; gr = ready_a; gf = full_a; gw = int'(words_a);
            end
            checks = checks + 1;
            if (gd !== e.data || gc != e.crst || gr != e.rdy || gf != e.full || gw != e.words) begin
                errors = errors + 1;
                $display("FAIL %s: got data=%h cpu_rst=%0b ready=%0b full=%0b words=%0d, expected data=%h cpu_rst=%0b ready=%0b full=%0b words=%0d",
                         e.name, gd, gc, gr, gf, gw, e.data, e.crst, e.rdy, e.full, e.words);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input bit last);
        if (sel) begin valid_b = 1'b1; byte_b = b; last_b = last; end
        else     begin valid_a = 1'b1; byte_a = b; last_a = last; end
        step();
        valid_a = 1'b0; valid_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    endtask

    task automatic check(input bit sel, input string name, input bit ce, input logic [31:0] addr,
                         input logic [31:0] data, input bit crst, input bit rdy, input bit full,
                         input int words);
        exp_t e;
        if (sel) begin ce_b = ce; addr_b = addr; end
        else     begin ce_a = ce; addr_a = addr; end
        e.name = name; e.sel = sel; e.data = data; e.crst = crst;
        e.rdy = rdy; e.full = full; e.words = words;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] img1 [8];
        logic [7:0] img2 [6];
        img1 = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
        img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        rst_a = 1'b1; ce_a = 1'b0; addr_a = '0; valid_a = 1'b0; byte_a = '0; last_a = 1'b0; reload_a = 1'b0;
        rst_b = 1'b1; ce_b = 1'b0; addr_b = '0; valid_b = 1'b0; byte_b = '0; last_b = 1'b0; reload_b = 1'b0;
        step();
        step();
        check(0, "reset_a", 1, 32'h0, 32'h0, 1, 1, 0, 0);
        check(1, "reset_b", 1, 32'h0, 32'h0, 1, 1, 0, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // Two-word image with last on the 8th byte
        for (int i = 0; i < 7; i++) send(0, img1[i], 1'b0);
        check(0, "after_7_bytes", 1, 32'h0, 32'h0, 1, 1, 0, 1);
        send(0, img1[7], 1'b1);
        check(0, "img1_word1", 1, 32'h4, 32'h34020020, 0, 0, 0, 2);
        check(0, "img1_word0", 1, 32'h0, 32'h34011100, 0, 0, 0, 2);
        check(0, "ce_low", 0, 32'h4, 32'h0, 0, 0, 0, 2);
        check(0, "alias_1003", 1, 32'h1003, 32'h34011100, 0, 0, 0, 2);

        // Stray byte in RUN is dropped
        send(0, 8'h55, 1'b1);
        check(0, "stray_in_run", 1, 32'h0, 32'h34011100, 0, 0, 0, 2);

        // Reload with a simultaneous stray byte: byte must not be accepted
        reload_a = 1'b1; valid_a = 1'b1; byte_a = 8'hFF; last_a = 1'b1;
        step();
        reload_a = 1'b0; valid_a = 1'b0; last_a = 1'b0;
        check(0, "reload_enter_load", 1, 32'h0, 32'h0, 1, 1, 0, 0);

        // One-word reload keeps old mem[1]
        send(0, 8'h12, 1'b0); send(0, 8'h34, 1'b0); send(0, 8'h56, 1'b0); send(0, 8'h78, 1'b1);
        check(0, "reload_word0", 1, 32'h0, 32'h12345678, 0, 0, 0, 1);
        check(0, "old_word1_kept", 1, 32'h4, 32'h34020020, 0, 0, 0, 1);

        // Reload, then a second pulse while in LOAD is ignored
        reload_a = 1'b1; step(); reload_a = 1'b0;
        check(0, "reload2", 1, 32'h0, 32'h0, 1, 1, 0, 0);
        reload_a = 1'b1; step(); reload_a = 1'b0;
        for (int i = 0; i < 5; i++) send(0, img2[i], 1'b0);
        send(0, img2[5], 1'b1);
        check(0, "img2_word0", 1, 32'h0, 32'hAABBCCDD, 0, 0, 0, 2);
        check(0, "img2_padded", 1, 32'h4, 32'h11220000, 0, 0, 0, 2);

        // rst together with reload
        rst_a = 1'b1; reload_a = 1'b1; step(); rst_a = 1'b0; reload_a = 1'b0;
        check(0, "rst_and_reload", 1, 32'h0, 32'h0, 1, 1, 0, 0);

        // rst mid-word discards the partial bytes
        send(0, 8'h77, 1'b0); send(0, 8'h88, 1'b0);
        check(0, "partial_word", 1, 32'h0, 32'h0, 1, 1, 0, 0);
        rst_a = 1'b1; step(); rst_a = 1'b0;
        send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b0); send(0, 8'h03, 1'b0); send(0, 8'h04, 1'b1);
        check(0, "after_mid_rst", 1, 32'h0, 32'h01020304, 0, 0, 0, 1);
        check(0, "mem1_persists", 1, 32'h4, 32'h11220000, 0, 0, 0, 1);

        // Small memory: capacity stop after 16 bytes
        for (int i = 0; i < 20; i++) begin
            send(1, 8'(8'h10 + i), 1'b0);
            if (i == 14) check(1, "small_15_bytes", 1, 32'h0, 32'h0, 1, 1, 0, 3);
            if (i == 15) check(1, "small_full", 1, 32'h0, 32'h10111213, 0, 0, 1, 4);
        end
        check(1, "small_w0", 1, 32'h0, 32'h10111213, 0, 0, 1, 4);
        check(1, "small_w1", 1, 32'h4, 32'h14151617, 0, 0, 1, 4);
        check(1, "small_w2", 1, 32'h8, 32'h18191A1B, 0, 0, 1, 4);
        check(1, "small_w3", 1, 32'hC, 32'h1C1D1E1F, 0, 0, 1, 4);
        check(1, "small_alias", 1, 32'h10, 32'h10111213, 0, 0, 1, 4);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
